// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war referee.
package tug_pkg;
  typedef enum logic [1:0] {PLAY, GAP, OVER} ref_state_t;
  typedef enum logic {SIDE_L, SIDE_R} side_t;
  localparam logic [9:0] LFSR_SEED = 10'h001;
endpackage

// File: rtl/key_conditioner.sv
// Raw key synchronizer followed by a rising-edge detector; one press pulse per key press.
module key_conditioner
  import tug_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key_raw,
  output logic press
);
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   edge_reg;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge Clock) begin
        if (Reset)        sync_reg[gi] <= 1'b0;
        else if (gi == 0) sync_reg[gi] <= key_raw;
        else              sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
      end
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (Reset) edge_reg <= 1'b0;
    else       edge_reg <= sync_reg[SYNC_STAGES-1];
  end

  assign press = sync_reg[SYNC_STAGES-1] & ~edge_reg;
endmodule

// File: rtl/tug_referee.sv
// Tug-of-war referee: rope position, round decisions, win pulses and match end.
// Optional CPU_PLAYER_EN makes the right side an LFSR-driven computer player.
module tug_referee
  import tug_pkg::*;
#(
  parameter int NUM_LEDS     = 9,
  parameter int SYNC_STAGES  = 2,
  parameter int MATCH_POINTS = 7,
  parameter int ROUND_GAP    = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                key_l,
  input  logic                key_r,
  input  logic [8:0]          cpu_speed,
  output logic [NUM_LEDS-1:0] leds,
  output logic                win_l,
  output logic                win_r,
  output logic                match_over
);
  localparam int CENTER = (NUM_LEDS - 1) / 2;
  localparam int POS_W  = $clog2(NUM_LEDS);
  localparam int CNT_W  = $clog2(MATCH_POINTS + 1);
  localparam int GAP_W  = $clog2(ROUND_GAP + 1);

  logic press_l, press_r, key_press_r;

  key_conditioner #(.SYNC_STAGES(SYNC_STAGES)) u_cond_l (
    .Clock(Clock), .Reset(Reset), .key_raw(key_l), .press(press_l)
  );
  key_conditioner #(.SYNC_STAGES(SYNC_STAGES)) u_cond_r (
    .Clock(Clock), .Reset(Reset), .key_raw(key_r), .press(key_press_r)
  );

`ifdef CPU_PLAYER_EN
  logic [9:0] lfsr_reg;
  logic       unused_key_press;
  always_ff @(posedge Clock) begin
    if (Reset) lfsr_reg <= LFSR_SEED;
    else       lfsr_reg <= {lfsr_reg[8:0], lfsr_reg[9] ^ lfsr_reg[6]};
  end
  assign press_r          = (lfsr_reg[8:0] < cpu_speed);
  assign unused_key_press = key_press_r;
`else
  logic unused_cpu_speed;
  assign press_r          = key_press_r;
  assign unused_cpu_speed = ^cpu_speed;
`endif

  ref_state_t       state_reg, state_next;
  side_t            winner_reg, winner_next;
  logic [POS_W-1:0] pos_reg, pos_next;
  logic [CNT_W-1:0] cnt_l_reg, cnt_l_next, cnt_r_reg, cnt_r_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic             win_l_reg, win_l_next, win_r_reg, win_r_next;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg  <= PLAY;
      winner_reg <= SIDE_L;
      pos_reg    <= POS_W'(CENTER);
      cnt_l_reg  <= '0;
      cnt_r_reg  <= '0;
      gap_reg    <= '0;
      win_l_reg  <= 1'b0;
      win_r_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      winner_reg <= winner_next;
      pos_reg    <= pos_next;
      cnt_l_reg  <= cnt_l_next;
      cnt_r_reg  <= cnt_r_next;
      gap_reg    <= gap_next;
      win_l_reg  <= win_l_next;
      win_r_reg  <= win_r_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    winner_next = winner_reg;
    pos_next    = pos_reg;
    cnt_l_next  = cnt_l_reg;
    cnt_r_next  = cnt_r_reg;
    gap_next    = gap_reg;
    win_l_next  = 1'b0;
    win_r_next  = 1'b0;
    case (state_reg)
      PLAY: begin
        // Simultaneous presses cancel; only a lone press moves the rope.
        if (press_l && !press_r) begin
          if (pos_reg == POS_W'(NUM_LEDS - 1)) begin
            win_l_next  = 1'b1;
            cnt_l_next  = cnt_l_reg + 1'b1;
            pos_next    = POS_W'(CENTER);
            winner_next = SIDE_L;
            gap_next    = '0;
            state_next  = (cnt_l_reg == CNT_W'(MATCH_POINTS - 1)) ? OVER : GAP;
          end else begin
            pos_next = pos_reg + 1'b1;
          end
        end else if (press_r && !press_l) begin
          if (pos_reg == '0) begin
            win_r_next  = 1'b1;
            cnt_r_next  = cnt_r_reg + 1'b1;
            pos_next    = POS_W'(CENTER);
            winner_next = SIDE_R;
            gap_next    = '0;
            state_next  = (cnt_r_reg == CNT_W'(MATCH_POINTS - 1)) ? OVER : GAP;
          end else begin
            pos_next = pos_reg - 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_reg == GAP_W'(ROUND_GAP - 1)) state_next = PLAY;
        else                                  gap_next   = gap_reg + 1'b1;
      end
      OVER:    ;
      default: state_next = PLAY;
    endcase
  end

  always_comb begin
    leds = '0;
    case (state_reg)
      PLAY:    leds = NUM_LEDS'(1) << pos_reg;
      OVER:    leds = (winner_reg == SIDE_L) ? NUM_LEDS'(1) << (NUM_LEDS - 1) : NUM_LEDS'(1);
      default: leds = '0;
    endcase
  end

  assign win_l      = win_l_reg;
  assign win_r      = win_r_reg;
  assign match_over = (state_reg == OVER);
endmodule

// File: tb/tb_tug_referee.sv
// Scoreboarded directed bench for tug_referee: expected win pulses queued, monitor pops them.
module tb_tug_referee;
  import tug_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       key_l, key_r;
  logic [8:0] cpu_speed;
  logic [8:0] leds;
  logic       win_l, win_r, match_over;

  int    vectors = 0;
  int    miscompares = 0;
  side_t exp_q[$];

  localparam logic [8:0] CTR = 9'b000010000;

  tug_referee dut (
    .Clock(Clock), .Reset(Reset), .key_l(key_l), .key_r(key_r), .cpu_speed(cpu_speed),
    .leds(leds), .win_l(win_l), .win_r(win_r), .match_over(match_over)
  );

  always #5 Clock = ~Clock;

  task automatic cmp(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end else
      $display("ok   %s: %0d", nm, act);
  endtask

  // Win-pulse monitor: every pulse must match the head of the expectation queue.
  always @(negedge Clock) begin
    if (!Reset && (win_l || win_r)) begin
      vectors++;
      if (win_l && win_r) begin
        miscompares++;
        $display("FAIL win_both: win_l=1 win_r=1 expected one-hot");
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL win_unexpected: win_l=%0b win_r=%0b expected none", win_l, win_r);
      end else begin
        side_t e, g;
        e = exp_q.pop_front();
        g = win_l ? SIDE_L : SIDE_R;
        if (g != e) begin
          miscompares++;
          $display("FAIL win_side: got %s expected %s", g.name(), e.name());
        end else
          $display("ok   win_pulse %s", g.name());
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic check_state(string nm, logic [8:0] exp_leds, logic exp_mo);
    @(negedge Clock);
    cmp({nm, "_leds"}, int'(leds), int'(exp_leds));
    cmp({nm, "_match_over"}, int'(match_over), int'(exp_mo));
    @(posedge Clock);
    #1;
  endtask

  task automatic press_left();
    key_l = 1'b1; tick(3); key_l = 1'b0; tick(3);
  endtask

  task automatic press_right();
    key_r = 1'b1; tick(3); key_r = 1'b0; tick(3);
  endtask

  task automatic do_reset();
    Reset = 1'b1; key_l = 1'b0; key_r = 1'b0;
    tick(3);
    Reset = 1'b0;
    tick(1);
  endtask

  initial begin
    logic [8:0] one;
    bit         seen;
    one = 9'd1;
    Reset = 1'b1; key_l = 1'b0; key_r = 1'b0; cpu_speed = 9'd0;
    tick(3);
    check_state("reset", CTR, 1'b0);
    Reset = 1'b0;

    // T1: idle 100 cycles
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      if (leds !== CTR || match_over !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_cycle%0d: leds=%b mo=%0b expected %b mo=0", i, leds, match_over, CTR);
      end
      vectors++;
    end
    $display("ok   idle 100 cycles checked");
    tick(1);

    // T2: four left moves then a left win
    for (int i = 1; i <= 4; i++) begin
      press_left();
      check_state($sformatf("left_move%0d", i), one << (4 + i), 1'b0);
    end
    exp_q.push_back(SIDE_L);
    key_l = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge Clock);
      if (win_l) seen = 1;
    end
    if (!seen) begin
      cmp("t2_win_timeout", 0, 1);
    end else begin
      cmp("t2_gap0_leds", int'(leds), 0);
      for (int k = 1; k < 4; k++) begin
        @(negedge Clock);
        if (k == 1) cmp("t2_win_one_cycle", int'(win_l), 0);
        cmp($sformatf("t2_gap%0d_leds", k), int'(leds), 0);
      end
      @(negedge Clock);
      cmp("t2_after_gap_leds", int'(leds), int'(CTR));
    end
    @(posedge Clock); #1;
    key_l = 1'b0;
    tick(3);

    // T3: simultaneous presses cancel; a held key moves once
    key_l = 1'b1; key_r = 1'b1;
    tick(6);
    check_state("t3_cancel", CTR, 1'b0);
    key_l = 1'b0; key_r = 1'b0;
    tick(3);
    key_l = 1'b1;
    tick(50);
    check_state("t3_held", one << 5, 1'b0);
    key_l = 1'b0;
    tick(3);

`ifndef CPU_PLAYER_EN
    press_right();
    check_state("right_move1", CTR, 1'b0);
    for (int i = 0; i < 4; i++) press_right();
    check_state("right_at_edge", one, 1'b0);
    exp_q.push_back(SIDE_R);
    press_right();
    tick(8);
    check_state("right_win_back", CTR, 1'b0);
`endif

    // T4: Reset during GAP, then Reset killing a pending win
    do_reset();
    for (int i = 0; i < 4; i++) press_left();
    check_state("t4_edge", one << 8, 1'b0);
    exp_q.push_back(SIDE_L);
    press_left();
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    check_state("t4_reset_in_gap", CTR, 1'b0);
    for (int i = 0; i < 4; i++) press_left();
    key_l = 1'b1;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    Reset = 1'b1; key_l = 1'b0;
    tick(2);
    Reset = 1'b0;
    check_state("t4_reset_kills_win", CTR, 1'b0);
    tick(10);
    check_state("t4_still_centre", CTR, 1'b0);

    // T5: seven left wins end the match
    do_reset();
    for (int w = 0; w < 7; w++) begin
      check_state($sformatf("t5_before_win%0d", w + 1), CTR, 1'b0);
      for (int i = 0; i < 4; i++) press_left();
      exp_q.push_back(SIDE_L);
      press_left();
      tick(6);
    end
    check_state("t5_match_over", 9'b100000000, 1'b1);
    press_left(); press_left(); press_right(); press_right();
    check_state("t5_frozen", 9'b100000000, 1'b1);
    do_reset();
    check_state("t5_after_reset", CTR, 1'b0);

`ifdef CPU_PLAYER_EN
    // T6: fastest CPU wins a round from centre
    exp_q.push_back(SIDE_R);
    cpu_speed = 9'h1FF;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      key_r = ~key_r;
      @(negedge Clock);
      if (win_r) seen = 1;
    end
    cmp("t6_cpu_win", int'(seen), 1);
    @(posedge Clock); #1;
    cpu_speed = 9'd0; key_r = 1'b0;
    tick(10);
    check_state("t6_cpu_idle", CTR, 1'b0);
`endif

    tick(10);
    cmp("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
